// File: rtl/matmul_engine.sv
// matmul_engine
//   Integer matrix-multiply engine: C = A x B. A (M x K, row-major) comes from
//   the input SRAM, B (K x N, column-major) from the weight SRAM, and C
//   (M x N, row-major, no header) goes to the result SRAM. Word 0 of the
//   input and weight SRAMs is a header {rows, cols}, each DATA_W/2 bits wide.
//   One signed product is accumulated per cycle; each result element takes
//   K+2 cycles (K reads, 1 drain, 1 write).
//
// Ports
//   clk, reset                          clock (rising edge), async active-high reset
//   dut_valid / dut_ready               start request / idle-and-ready
//   dut_err                             dimension error flag of the last job
//   dut__tb__sram_*_write_enable/address/data   SRAM write side (only result used)
//   dut__tb__sram_*_read_address        SRAM read addresses (result tied 0)
//   tb__dut__sram_*_read_data           SRAM read data, 1-cycle latency
module matmul_engine #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 12,
  parameter int ACC_W    = 2*DATA_W+8,
  parameter bit SATURATE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dut_valid,
  output logic              dut_ready,
  output logic              dut_err,
  output logic              dut__tb__sram_input_write_enable,
  output logic [ADDR_W-1:0] dut__tb__sram_input_write_address,
  output logic [DATA_W-1:0] dut__tb__sram_input_write_data,
  output logic [ADDR_W-1:0] dut__tb__sram_input_read_address,
  input  logic [DATA_W-1:0] tb__dut__sram_input_read_data,
  output logic              dut__tb__sram_weight_write_enable,
  output logic [ADDR_W-1:0] dut__tb__sram_weight_write_address,
  output logic [DATA_W-1:0] dut__tb__sram_weight_write_data,
  output logic [ADDR_W-1:0] dut__tb__sram_weight_read_address,
  input  logic [DATA_W-1:0] tb__dut__sram_weight_read_data,
  output logic              dut__tb__sram_result_write_enable,
  output logic [ADDR_W-1:0] dut__tb__sram_result_write_address,
  output logic [DATA_W-1:0] dut__tb__sram_result_write_data,
  output logic [ADDR_W-1:0] dut__tb__sram_result_read_address,
  input  logic [DATA_W-1:0] tb__dut__sram_result_read_data
);

  localparam int HW = DATA_W/2;
  localparam logic [HW-1:0] ONE_H = HW'(1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_HDRW, S_CHECK, S_RUN, S_DRAIN, S_WRITE, S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  // Header fields (data path, not reset)
  logic [HW-1:0] r_m, r_kd, r_bk, r_n;
  // Loop counters and address bases
  logic [HW-1:0] r_i, r_j, r_k;
  logic [ADDR_W-1:0] r_a_row, r_b_col;
  // Read-issue / read-data-valid flags travelling with the operand stream
  logic r_vld_p0, r_vld_p1;
  logic signed [ACC_W-1:0] r_acc;

  logic w_last_i, w_last_j, w_last_k, w_dim_err;
  logic signed [DATA_W-1:0]   w_a, w_b;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext, w_acc_sum;
  logic w_unused;

  // Clamp to signed DATA_W range, or keep the low DATA_W bits.
  function automatic logic [DATA_W-1:0] f_convert(input logic signed [ACC_W-1:0] acc);
    logic [DATA_W-1:0] res;
    res = acc[DATA_W-1:0];
    if (SATURATE) begin
      if (acc > SAT_MAX)      res = SAT_MAX[DATA_W-1:0];
      else if (acc < SAT_MIN) res = SAT_MIN[DATA_W-1:0];
    end
    return res;
  endfunction

  assign dut__tb__sram_input_write_enable   = 1'b0;
  assign dut__tb__sram_input_write_address  = '0;
  assign dut__tb__sram_input_write_data     = '0;
  assign dut__tb__sram_weight_write_enable  = 1'b0;
  assign dut__tb__sram_weight_write_address = '0;
  assign dut__tb__sram_weight_write_data    = '0;
  assign dut__tb__sram_result_read_address  = '0;
  assign w_unused = ^tb__dut__sram_result_read_data;

  assign w_last_i  = (r_i == r_m  - ONE_H);
  assign w_last_j  = (r_j == r_n  - ONE_H);
  assign w_last_k  = (r_k == r_kd - ONE_H);
  assign w_dim_err = (r_kd != r_bk) || (r_m == '0) || (r_n == '0) || (r_kd == '0);

  assign w_a        = tb__dut__sram_input_read_data;
  assign w_b        = tb__dut__sram_weight_read_data;
  assign w_prod     = w_a * w_b;
  assign w_prod_ext = ACC_W'(w_prod);
  assign w_acc_sum  = r_acc + w_prod_ext;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (dut_valid) w_next = S_HDR;
      S_HDR:   w_next = S_HDRW;
      S_HDRW:  w_next = S_CHECK;
      S_CHECK: w_next = w_dim_err ? S_DONE : S_RUN;
      S_RUN:   if (w_last_k) w_next = S_DRAIN;
      S_DRAIN: w_next = S_WRITE;
      S_WRITE: w_next = (w_last_i && w_last_j) ? S_DONE : S_RUN;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      dut_ready <= 1'b1;
      dut_err  <= 1'b0;
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
      r_i      <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_a_row  <= '0;
      r_b_col  <= '0;
      dut__tb__sram_input_read_address   <= '0;
      dut__tb__sram_weight_read_address  <= '0;
      dut__tb__sram_result_write_enable  <= 1'b0;
      dut__tb__sram_result_write_address <= '0;
      dut__tb__sram_result_write_data    <= '0;
    end else begin
      r_state <= w_next;
      // Registered from the current state, so ready rises one cycle after IDLE entry.
      dut_ready <= (r_state == S_IDLE) && !dut_valid;
      // Stage p0: operand addresses issued this cycle
      r_vld_p0 <= (w_next == S_RUN);
      // Stage p1: SRAM data for those addresses is on the read ports
      r_vld_p1 <= r_vld_p0;
      dut__tb__sram_result_write_enable <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (dut_valid) begin
            dut_err <= 1'b0;
            dut__tb__sram_input_read_address  <= '0;
            dut__tb__sram_weight_read_address <= '0;
          end
        end
        S_CHECK: begin
          if (w_dim_err) begin
            dut_err <= 1'b1;
          end else begin
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_a_row <= ADDR_W'(1);
            r_b_col <= ADDR_W'(1);
            dut__tb__sram_input_read_address   <= ADDR_W'(1);
            dut__tb__sram_weight_read_address  <= ADDR_W'(1);
            dut__tb__sram_result_write_address <= '0;
          end
        end
        S_RUN: begin
          if (!w_last_k) begin
            r_k <= r_k + ONE_H;
            dut__tb__sram_input_read_address  <= dut__tb__sram_input_read_address + ADDR_W'(1);
            dut__tb__sram_weight_read_address <= dut__tb__sram_weight_read_address + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          // Final product arrives this cycle; fold it in directly on the way out.
          dut__tb__sram_result_write_enable <= 1'b1;
          dut__tb__sram_result_write_data   <= f_convert(w_acc_sum);
        end
        S_WRITE: begin
          dut__tb__sram_result_write_address <= dut__tb__sram_result_write_address + ADDR_W'(1);
          r_k <= '0;
          if (w_last_j) begin
            r_j     <= '0;
            r_i     <= r_i + ONE_H;
            r_a_row <= r_a_row + ADDR_W'(r_kd);
            r_b_col <= ADDR_W'(1);
            dut__tb__sram_input_read_address  <= r_a_row + ADDR_W'(r_kd);
            dut__tb__sram_weight_read_address <= ADDR_W'(1);
          end else begin
            r_j     <= r_j + ONE_H;
            r_b_col <= r_b_col + ADDR_W'(r_kd);
            dut__tb__sram_input_read_address  <= r_a_row;
            dut__tb__sram_weight_read_address <= r_b_col + ADDR_W'(r_kd);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_HDRW) begin
      r_m  <= tb__dut__sram_input_read_data[DATA_W-1:HW];
      r_kd <= tb__dut__sram_input_read_data[HW-1:0];
      r_bk <= tb__dut__sram_weight_read_data[DATA_W-1:HW];
      r_n  <= tb__dut__sram_weight_read_data[HW-1:0];
    end
    if (r_state == S_CHECK || r_state == S_WRITE) r_acc <= '0;
    else if (r_vld_p1)                            r_acc <= w_acc_sum;
  end

endmodule

// File: tb/tb_matmul_engine.sv
// Testbench for matmul_engine: two instances (saturating and truncating)
// share the same stimulus and SRAM contents; each has its own result SRAM.
module tb_matmul_engine;
  localparam int DW = 32;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic reset;
  logic dut_valid;

  logic rdy_s, err_s, iwe_s, wwe_s, rwe_s;
  logic [AW-1:0] iwa_s, wwa_s, rwa_s, ira_s, wra_s, rra_s;
  logic [DW-1:0] iwd_s, wwd_s, rwd_s, ird_s, wrd_s;
  logic rdy_t, err_t, iwe_t, wwe_t, rwe_t;
  logic [AW-1:0] iwa_t, wwa_t, rwa_t, ira_t, wra_t, rra_t;
  logic [DW-1:0] iwd_t, wwd_t, rwd_t, ird_t, wrd_t;
  logic [DW-1:0] rrd = '0;

  logic [DW-1:0] memA [0:63];
  logic [DW-1:0] memB [0:63];
  logic [DW-1:0] res_s [0:63];
  logic [DW-1:0] res_t [0:63];
  int tag_s [0:63];
  int tag_t [0:63];
  int nw_s = 0;
  int nw_t = 0;
  int epoch = 0;
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_s [0:3];
  logic [DW-1:0] exp_t [0:3];

  matmul_engine #(.DATA_W(DW), .ADDR_W(AW), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .dut_valid(dut_valid), .dut_ready(rdy_s), .dut_err(err_s),
    .dut__tb__sram_input_write_enable(iwe_s), .dut__tb__sram_input_write_address(iwa_s),
    .dut__tb__sram_input_write_data(iwd_s), .dut__tb__sram_input_read_address(ira_s),
    .tb__dut__sram_input_read_data(ird_s),
    .dut__tb__sram_weight_write_enable(wwe_s), .dut__tb__sram_weight_write_address(wwa_s),
    .dut__tb__sram_weight_write_data(wwd_s), .dut__tb__sram_weight_read_address(wra_s),
    .tb__dut__sram_weight_read_data(wrd_s),
    .dut__tb__sram_result_write_enable(rwe_s), .dut__tb__sram_result_write_address(rwa_s),
    .dut__tb__sram_result_write_data(rwd_s), .dut__tb__sram_result_read_address(rra_s),
    .tb__dut__sram_result_read_data(rrd)
  );

  matmul_engine #(.DATA_W(DW), .ADDR_W(AW), .SATURATE(1'b0)) u_trn (
    .clk(clk), .reset(reset), .dut_valid(dut_valid), .dut_ready(rdy_t), .dut_err(err_t),
    .dut__tb__sram_input_write_enable(iwe_t), .dut__tb__sram_input_write_address(iwa_t),
    .dut__tb__sram_input_write_data(iwd_t), .dut__tb__sram_input_read_address(ira_t),
    .tb__dut__sram_input_read_data(ird_t),
    .dut__tb__sram_weight_write_enable(wwe_t), .dut__tb__sram_weight_write_address(wwa_t),
    .dut__tb__sram_weight_write_data(wwd_t), .dut__tb__sram_weight_read_address(wra_t),
    .tb__dut__sram_weight_read_data(wrd_t),
    .dut__tb__sram_result_write_enable(rwe_t), .dut__tb__sram_result_write_address(rwa_t),
    .dut__tb__sram_result_write_data(rwd_t), .dut__tb__sram_result_read_address(rra_t),
    .tb__dut__sram_result_read_data(rrd)
  );

  always #5 clk = ~clk;

  // 1-cycle latency SRAM models
  always @(posedge clk) begin
    ird_s <= memA[ira_s[5:0]];
    wrd_s <= memB[wra_s[5:0]];
    ird_t <= memA[ira_t[5:0]];
    wrd_t <= memB[wra_t[5:0]];
    if (rwe_s) begin
      res_s[rwa_s[5:0]] <= rwd_s;
      tag_s[rwa_s[5:0]] <= epoch;
      nw_s <= nw_s + 1;
    end
    if (rwe_t) begin
      res_t[rwa_t[5:0]] <= rwd_t;
      tag_t[rwa_t[5:0]] <= epoch;
      nw_t <= nw_t + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic tied_or();
    return |{iwe_s, wwe_s, iwa_s, wwa_s, iwd_s, wwd_s, rra_s,
             iwe_t, wwe_t, iwa_t, wwa_t, iwd_t, wwd_t, rra_t};
  endfunction

  task automatic start_job(output logic rdy_at, output logic err_at);
    @(negedge clk);
    dut_valid = 1'b1;
    @(posedge clk);
    #1;
    dut_valid = 1'b0;
    rdy_at = rdy_s;
    err_at = err_s;
  endtask

  task automatic job(input string nm, input int exp_cyc, input logic exp_err, input int nexp);
    int b_s;
    int b_t;
    int cyc;
    logic rdy_at;
    logic err_at;
    b_s = nw_s;
    b_t = nw_t;
    epoch++;
    start_job(rdy_at, err_at);
    cyc = -1;
    for (int n = 1; n <= 2000; n++) begin
      @(posedge clk);
      #1;
      if (rdy_s) begin
        cyc = n;
        break;
      end
    end
    chk({nm, ".ready_fall"}, 64'(rdy_at), 64'(0));
    chk({nm, ".err_clear"}, 64'(err_at), 64'(0));
    chk({nm, ".cycles"}, 64'(cyc), 64'(exp_cyc));
    chk({nm, ".ready_t"}, 64'(rdy_t), 64'(1));
    chk({nm, ".err_s"}, 64'(err_s), 64'(exp_err));
    chk({nm, ".err_t"}, 64'(err_t), 64'(exp_err));
    chk({nm, ".nwr_s"}, 64'(nw_s - b_s), 64'(nexp));
    chk({nm, ".nwr_t"}, 64'(nw_t - b_t), 64'(nexp));
    for (int i = 0; i < nexp; i++) begin
      chk($sformatf("%s.c%0d_s", nm, i), 64'(res_s[i]), 64'(exp_s[i]));
      chk($sformatf("%s.c%0d_t", nm, i), 64'(res_t[i]), 64'(exp_t[i]));
      chk($sformatf("%s.tag%0d_s", nm, i), 64'(tag_s[i]), 64'(epoch));
      chk($sformatf("%s.tag%0d_t", nm, i), 64'(tag_t[i]), 64'(epoch));
    end
  endtask

  task automatic load_basic();
    memA[0] = {16'd2, 16'd3};
    memA[1] = 32'd1; memA[2] = 32'd2; memA[3] = 32'd3;
    memA[4] = 32'd4; memA[5] = 32'd5; memA[6] = 32'd6;
    memB[0] = {16'd3, 16'd2};
    memB[1] = 32'd7; memB[2] = 32'd9;  memB[3] = 32'd11;
    memB[4] = 32'd8; memB[5] = 32'd10; memB[6] = 32'd12;
    exp_s[0] = 32'd58;  exp_s[1] = 32'd64;  exp_s[2] = 32'd139; exp_s[3] = 32'd154;
    exp_t[0] = 32'd58;  exp_t[1] = 32'd64;  exp_t[2] = 32'd139; exp_t[3] = 32'd154;
  endtask

  task automatic load_1x1();
    memA[0] = {16'd1, 16'd1};
    memA[1] = 32'hFFFF_FFFD;
    memB[0] = {16'd1, 16'd1};
    memB[1] = 32'd5;
    exp_s[0] = 32'hFFFF_FFF1;
    exp_t[0] = 32'hFFFF_FFF1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      memA[i] = '0;
      memB[i] = '0;
    end
    reset = 1'b1;
    dut_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ready", 64'(rdy_s), 64'(1));
    chk("rst.err", 64'(err_s), 64'(0));
    chk("rst.we", 64'(rwe_s), 64'(0));
    chk("rst.waddr", 64'(rwa_s), 64'(0));
    chk("rst.wdata", 64'(rwd_s), 64'(0));
    chk("rst.raddr", 64'({ira_s, wra_s}), 64'(0));
    chk("rst.tied", 64'(tied_or()), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rel.ready", 64'(rdy_s), 64'(1));

    load_basic();
    job("basic", 25, 1'b0, 4);

    load_1x1();
    job("one", 8, 1'b0, 1);

    memA[0] = {16'd1, 16'd2};
    memA[1] = 32'h7FFF_FFFF; memA[2] = 32'h7FFF_FFFF;
    memB[0] = {16'd2, 16'd1};
    memB[1] = 32'd2; memB[2] = 32'd2;
    exp_s[0] = 32'h7FFF_FFFF;
    exp_t[0] = 32'hFFFF_FFFC;
    job("sat", 9, 1'b0, 1);

    memA[0] = {16'd2, 16'd3};
    memB[0] = {16'd4, 16'd2};
    job("dimerr", 5, 1'b1, 0);

    load_1x1();
    job("clear", 8, 1'b0, 1);

    memA[0] = {16'd0, 16'd3};
    memB[0] = {16'd3, 16'd2};
    job("zerodim", 5, 1'b1, 0);

    // Reset during the second element of the basic job, then restart.
    load_basic();
    epoch++;
    begin
      logic rdy_at;
      logic err_at;
      start_job(rdy_at, err_at);
    end
    repeat (9) @(posedge clk);
    #1;
    chk("mid.waddr", 64'(rwa_s), 64'(1));
    chk("mid.wdata", 64'(rwd_s), 64'(58));
    reset = 1'b1;
    #1;
    chk("mid.ready", 64'(rdy_s), 64'(1));
    chk("mid.err", 64'(err_s), 64'(0));
    chk("mid.we", 64'({rwe_s, rwe_t}), 64'(0));
    chk("mid.waddr_rst", 64'(rwa_s), 64'(0));
    chk("mid.wdata_rst", 64'(rwd_s), 64'(0));
    chk("mid.raddr_rst", 64'({ira_s, wra_s, ira_t, wra_t}), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    job("restart", 25, 1'b0, 4);
    chk("end.tied", 64'(tied_or()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/matmul_engine.md
# matmul_engine

Parametrised integer matrix-multiply engine: computes C = A × B with A from the input SRAM, B from the weight SRAM and C written to the result SRAM, started and finished through the dut_valid/dut_ready handshake. It is the next generation of the single-precision MAC datapath. Changes from that datapath:
- Data width, address width and accumulator width are parameters.
- Arithmetic is signed fixed point, with optional saturation.
- Dimension checking is built in, with an error flag.

## Interface
- DATA_W, 32: SRAM word width, even; element and header width.
- ADDR_W, 12: SRAM address width.
- ACC_W, 2*DATA_W+8: accumulator width, signed.
- SATURATE, 1: 1 clamps the result to signed DATA_W range; 0 truncates to the low DATA_W bits.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous reset, active-high.
- dut_valid  in  1  start request.
- dut_ready  out  1  1 = idle and able to accept a start.
- dut_err  out  1  dimension error flag for the last job.
- dut__tb__sram_{input,weight,result}_write_enable  out  1  input/weight tied 0; result = write strobe.
- dut__tb__sram_{input,weight,result}_write_address  out  ADDR_W  input/weight tied 0.
- dut__tb__sram_{input,weight,result}_write_data  out  DATA_W  input/weight tied 0.
- dut__tb__sram_{input,weight,result}_read_address  out  ADDR_W  result read address tied 0.
- tb__dut__sram_{input,weight,result}_read_data  in  DATA_W  result read data unused.

## Operation
- **Header word (address 0 of input and weight SRAM):** rows = [DATA_W-1:DATA_W/2], cols = [DATA_W/2-1:0], both unsigned.
  - A is M×K, row-major: A(i,k) at 1+i*K+k.
  - B is K×N, column-major: B(k,j) at 1+j*K+k.
- **Result layout:** C(i,j) is written at i*N+j, with no header. Write order is i outer, j inner.
- **States:** IDLE, HDR (header read issued), HDRW (header data returns), CHECK, RUN, DRAIN, WRITE, DONE.
  - IDLE: dut_ready=1. dut_valid=1 → HDR, and dut_err clears.
  - HDR → HDRW → CHECK.
  - CHECK: if A.cols≠B.rows, or any of M, N, K is 0 → DONE with dut_err=1 and no result writes. Otherwise → RUN with i=j=k=0 and acc=0.
  - RUN: issues read addresses for A(i,k) and B(k,j); k increments each cycle; after k=K-1 → DRAIN.
  - DRAIN: accumulates the final product → WRITE.
  - WRITE: one result write. Then j advances; on j wrap, i advances. acc=0, k=0. → RUN, or → DONE after the final element.
  - DONE: → IDLE.
- **Accumulate:** one signed product per cycle, acc += A·B. Each product is sign-extended to ACC_W. Accumulator wrap beyond ACC_W is not detected.
- **Result conversion:**
  - SATURATE=1: acc > 2^(DATA_W-1)-1 → 0x7FFF…; acc < -2^(DATA_W-1) → 0x8000…; otherwise acc[DATA_W-1:0].
  - SATURATE=0: acc[DATA_W-1:0].
- dut_valid is ignored outside IDLE.
- Write addresses beyond 2^ADDR_W wrap modulo 2^ADDR_W; software keeps M*N within the SRAM.

## Timing
- SRAM read latency is 1 cycle: an address registered at edge t has its data valid during cycle t+1.
- All outputs are registered.
- **Reset values:** dut_ready=1, dut_err=0, all addresses 0, result write enable 0, write data 0, internal state IDLE.
- **Reset mid-job:** state returns to IDLE immediately (asynchronous). Any write strobe in flight is dropped. No partial state survives.
- **Start:** dut_ready falls on the edge after dut_valid is sampled high in IDLE.
- **Per element:** K+2 cycles (K RUN, 1 DRAIN, 1 WRITE). The result write enable is high for exactly one cycle per element.
- **Job length:** dut_ready returns high exactly 3 + M*N*(K+2) + 2 cycles after the start edge for a valid job. For an error job it returns high 5 cycles after the start edge.
- **Error flag timing:** dut_err is set with the DONE entry and holds until the next start.
- **Back-to-back jobs:** dut_valid held high continuously starts the next job on the first IDLE cycle.

## Test plan
- **Basic 2×3 × 3×2:** A=[1 2 3;4 5 6], B=[7 8;9 10;11 12], DATA_W=32 → writes 58,64,139,154 at addresses 0..3; dut_ready returns high 25 cycles after start; dut_err=0.
- **1×1×1 signed:** A=-3, B=5 → single write of 0xFFFFFFF1 at address 0; job takes 8 cycles.
- **Saturation:** A=[0x7FFFFFFF 0x7FFFFFFF], B=[2;2], 1×2×1 → 0x7FFFFFFF with SATURATE=1 and 0xFFFFFFFC with SATURATE=0.
- **Dimension error:** A header 2×3, B header 4×2 → dut_err=1, zero result writes, dut_ready high 5 cycles after start. A following valid job clears dut_err.
- **Zero dimension:** A header 0×3 → dut_err=1, no writes.
- **Reset mid-RUN:** assert reset during the 2nd element of the basic case → outputs take reset values within the same cycle. A restart after release produces the full correct 4-word result.
